// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction constants and the
// IEEE 1149.1 next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR    = 4'h0,
    TAP_EXIT1_DR    = 4'h1,
    TAP_SHIFT_DR    = 4'h2,
    TAP_PAUSE_DR    = 4'h3,
    TAP_SELECT_IR   = 4'h4,
    TAP_UPDATE_DR   = 4'h5,
    TAP_CAPTURE_DR  = 4'h6,
    TAP_SELECT_DR   = 4'h7,
    TAP_EXIT2_IR    = 4'h8,
    TAP_EXIT1_IR    = 4'h9,
    TAP_SHIFT_IR    = 4'hA,
    TAP_PAUSE_IR    = 4'hB,
    TAP_RUN_IDLE    = 4'hC,
    TAP_UPDATE_IR   = 4'hD,
    TAP_CAPTURE_IR  = 4'hE,
    TAP_TLR         = 4'hF
  } tap_state_e;

  // Truncated to the IR width at the point of use.
  localparam int unsigned INSTR_IDCODE = 32'h0000_0001;
  localparam int unsigned INSTR_BYPASS = 32'hFFFF_FFFF;

  function automatic tap_state_e next_state(input tap_state_e state, input logic tms);
    tap_state_e nxt;
    nxt = TAP_TLR;
    case (state)
      TAP_TLR:        nxt = tms ? TAP_TLR       : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   nxt = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:  nxt = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: nxt = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   nxt = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   nxt = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   nxt = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   nxt = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  nxt = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:  nxt = tms ? TAP_TLR       : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: nxt = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   nxt = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   nxt = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   nxt = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   nxt = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  nxt = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      default:        nxt = TAP_TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine: next-state logic plus the state register,
// which resets to Test-Logic-Reset.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e state_q;
  tap_state_e state_d;

  always_comb begin
    state_d = next_state(state_q, tms);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= TAP_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// JTAG TAP with IR, BYPASS, optional IDCODE and NUM_CHAINS user chains.
// Define JTAG_TAP_IDCODE_EN to include the IDCODE register.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH      = 5,
  parameter int unsigned NUM_CHAINS    = 2,
  parameter int unsigned CHAIN_WIDTH   = 32,
  parameter logic [31:0] IDCODE_VALUE  = 32'h0000_0001,
  parameter int unsigned CHAIN_IR_BASE = 'h10
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              io_tms,
  input  logic                              io_tdi,
  output logic                              io_tdo,
  output logic                              io_tdo_en,
  output logic [3:0]                        io_state,
  output logic [IR_WIDTH-1:0]               io_ir,
  output logic [NUM_CHAINS-1:0]             io_chain_capture,
  input  logic [NUM_CHAINS*CHAIN_WIDTH-1:0] io_chain_capture_data,
  output logic [NUM_CHAINS-1:0]             io_chain_update_valid,
  output logic [CHAIN_WIDTH-1:0]            io_chain_update_data
);

  localparam int unsigned DR_WIDTH = (CHAIN_WIDTH > 32) ? CHAIN_WIDTH : 32;
  localparam int unsigned DR_IDX_W = $clog2(DR_WIDTH);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS = IR_WIDTH'(INSTR_BYPASS);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(INSTR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_BYPASS;
`endif

  tap_state_e state;

  logic [IR_WIDTH-1:0]    ir_q, ir_d;
  logic [IR_WIDTH-1:0]    ir_shift_q, ir_shift_d;
  logic [DR_WIDTH-1:0]    dr_shift_q, dr_shift_d;
  logic [NUM_CHAINS-1:0]  update_valid_q, update_valid_d;
  logic [CHAIN_WIDTH-1:0] update_data_q, update_data_d;

  logic                   is_bypass;
  logic                   is_idcode;
  logic [NUM_CHAINS-1:0]  chain_sel;
  logic [CHAIN_WIDTH-1:0] chain_cap;
  logic [DR_IDX_W-1:0]    dr_msb;

  jtag_tap_fsm u_fsm (
    .clock (clock),
    .reset (reset),
    .tms   (io_tms),
    .state (state)
  );

  // Anything not recognised below falls through to BYPASS.
  assign is_bypass = (ir_q == IR_BYPASS);
`ifdef JTAG_TAP_IDCODE_EN
  assign is_idcode = (ir_q == IR_IDCODE);
`else
  assign is_idcode = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_chain_sel
      assign chain_sel[gi] = !is_bypass && !is_idcode &&
                             (32'(ir_q) == 32'(CHAIN_IR_BASE + gi));
    end
  endgenerate

  always_comb begin
    chain_cap = '0;
    for (int k = 0; k < NUM_CHAINS; k++) begin
      if (chain_sel[k]) chain_cap = io_chain_capture_data[k*CHAIN_WIDTH +: CHAIN_WIDTH];
    end
  end

  // TDI enters at the top bit of the selected register's width.
  always_comb begin
    if (|chain_sel)     dr_msb = DR_IDX_W'(CHAIN_WIDTH - 1);
    else if (is_idcode) dr_msb = DR_IDX_W'(31);
    else                dr_msb = '0;
  end

  always_comb begin
    ir_d           = ir_q;
    ir_shift_d     = ir_shift_q;
    dr_shift_d     = dr_shift_q;
    update_valid_d = '0;
    update_data_d  = update_data_q;
    case (state)
      TAP_TLR:        ir_d = IR_RESET;
      TAP_CAPTURE_IR: ir_shift_d = IR_WIDTH'(2'b01);
      TAP_SHIFT_IR:   ir_shift_d = {io_tdi, ir_shift_q[IR_WIDTH-1:1]};
      TAP_UPDATE_IR:  ir_d = ir_shift_q;
      TAP_CAPTURE_DR: begin
        dr_shift_d = '0;
        if (|chain_sel)     dr_shift_d[CHAIN_WIDTH-1:0] = chain_cap;
        else if (is_idcode) dr_shift_d[31:0] = IDCODE_VALUE;
      end
      TAP_SHIFT_DR: begin
        dr_shift_d         = dr_shift_q >> 1;
        dr_shift_d[dr_msb] = io_tdi;
      end
      TAP_UPDATE_DR: begin
        if (|chain_sel) begin
          update_valid_d = chain_sel;
          update_data_d  = dr_shift_q[CHAIN_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q           <= IR_RESET;
      ir_shift_q     <= '0;
      dr_shift_q     <= '0;
      update_valid_q <= '0;
      update_data_q  <= '0;
    end else begin
      ir_q           <= ir_d;
      ir_shift_q     <= ir_shift_d;
      dr_shift_q     <= dr_shift_d;
      update_valid_q <= update_valid_d;
      update_data_q  <= update_data_d;
    end
  end

  assign io_state              = state;
  assign io_tdo_en             = (state == TAP_SHIFT_DR) || (state == TAP_SHIFT_IR);
  assign io_tdo                = (state == TAP_SHIFT_IR) ? ir_shift_q[0] :
                                 (state == TAP_SHIFT_DR) ? dr_shift_q[0] : 1'b0;
  assign io_ir                 = (state == TAP_TLR) ? IR_RESET : ir_q;
  assign io_chain_capture      = (state == TAP_CAPTURE_DR) ? chain_sel : '0;
  assign io_chain_update_valid = update_valid_q;
  assign io_chain_update_data  = update_data_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Scenario bench for jtag_tap_controller: expected TDO bits and update
// events are queued as stimulus is driven and popped when observed.
module tb_jtag_tap_controller;

  localparam int IR_WIDTH    = 5;
  localparam int NUM_CHAINS  = 2;
  localparam int CHAIN_WIDTH = 32;
  localparam logic [31:0] IDCODE = 32'h4BA0_0477;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_IR = 5'h01;
`else
  localparam logic [IR_WIDTH-1:0] RESET_IR = 5'h1F;
`endif

  logic                              clock = 1'b0;
  logic                              reset = 1'b1;
  logic                              io_tms = 1'b1;
  logic                              io_tdi = 1'b0;
  logic                              io_tdo;
  logic                              io_tdo_en;
  logic [3:0]                        io_state;
  logic [IR_WIDTH-1:0]               io_ir;
  logic [NUM_CHAINS-1:0]             io_chain_capture;
  logic [NUM_CHAINS*CHAIN_WIDTH-1:0] io_chain_capture_data = '0;
  logic [NUM_CHAINS-1:0]             io_chain_update_valid;
  logic [CHAIN_WIDTH-1:0]            io_chain_update_data;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];
  logic [NUM_CHAINS+CHAIN_WIDTH-1:0] upd_exp_q[$];
  logic [NUM_CHAINS+CHAIN_WIDTH-1:0] upd_obs_q[$];
  int en_cnt, cap_cnt, upd_cnt;
  logic [NUM_CHAINS-1:0] cap_mask;

  jtag_tap_controller #(
    .IR_WIDTH      (IR_WIDTH),
    .NUM_CHAINS    (NUM_CHAINS),
    .CHAIN_WIDTH   (CHAIN_WIDTH),
    .IDCODE_VALUE  (IDCODE),
    .CHAIN_IR_BASE ('h10)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_tms                (io_tms),
    .io_tdi                (io_tdi),
    .io_tdo                (io_tdo),
    .io_tdo_en             (io_tdo_en),
    .io_state              (io_state),
    .io_ir                 (io_ir),
    .io_chain_capture      (io_chain_capture),
    .io_chain_capture_data (io_chain_capture_data),
    .io_chain_update_valid (io_chain_update_valid),
    .io_chain_update_data  (io_chain_update_data)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Mid-cycle observer: one sample per TAP state.
  always @(negedge clock) begin
    if (io_tdo_en) en_cnt++;
    if (|io_chain_capture) begin
      cap_cnt++;
      cap_mask = cap_mask | io_chain_capture;
    end
    if (|io_chain_update_valid) begin
      upd_cnt++;
      upd_obs_q.push_back({io_chain_update_valid, io_chain_update_data});
    end
  end

  task automatic clk(input logic tms, input logic tdi);
    io_tms = tms;
    io_tdi = tdi;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_obs();
    en_cnt = 0; cap_cnt = 0; upd_cnt = 0; cap_mask = '0;
    exp_q.delete(); upd_exp_q.delete(); upd_obs_q.delete();
  endtask

  // From Run-Test/Idle, one DR scan of n bits, back to Run-Test/Idle.
  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = io_tdo;
      clk(i == n - 1, din[i]);
    end
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  task automatic ir_scan(input logic [IR_WIDTH-1:0] din, output logic [IR_WIDTH-1:0] dout);
    dout = '0;
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    for (int i = 0; i < IR_WIDTH; i++) begin
      dout[i] = io_tdo;
      clk(i == IR_WIDTH - 1, din[i]);
    end
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_tms = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (io_state !== 4'hF) begin errors++; $display("FAIL reset_state: got %h expected f", io_state); end
    checks++; if (io_ir !== RESET_IR) begin errors++; $display("FAIL reset_ir: got %h expected %h", io_ir, RESET_IR); end
    checks++; if (io_tdo !== 1'b0 || io_tdo_en !== 1'b0) begin errors++; $display("FAIL reset_tdo: got tdo=%b en=%b expected 0/0", io_tdo, io_tdo_en); end
    checks++; if (io_chain_capture !== '0) begin errors++; $display("FAIL reset_capture: got %b expected 00", io_chain_capture); end
    checks++; if (io_chain_update_valid !== '0 || io_chain_update_data !== '0) begin errors++; $display("FAIL reset_update: got %b/%h expected 00/0", io_chain_update_valid, io_chain_update_data); end
    reset = 1'b0;
    clk(1'b0, 1'b0);
    checks++; if (io_state !== 4'hC) begin errors++; $display("FAIL reset_to_idle: got %h expected c", io_state); end
  endtask

  task automatic test_first_dr_scan();
    logic [63:0] din, dout, exp;
    clear_obs();
`ifdef JTAG_TAP_IDCODE_EN
    din = 64'h0;
    for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
    dr_scan(32, din, dout);
    exp = '0;
    for (int i = 0; i < 32; i++) exp[i] = exp_q.pop_front();
    checks++; if (dout !== exp) begin errors++; $display("FAIL idcode_read: got %h expected %h", dout, exp); end
    checks++; if (en_cnt != 32) begin errors++; $display("FAIL idcode_tdo_en: got %0d cycles expected 32", en_cnt); end
`else
    din = 64'h96;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_q.push_back(din[i]);
    dr_scan(8, din, dout);
    exp = '0;
    for (int i = 0; i < 8; i++) exp[i] = exp_q.pop_front();
    checks++; if (dout !== exp) begin errors++; $display("FAIL first_scan_bypass: got %h expected %h", dout, exp); end
    checks++; if (en_cnt != 8) begin errors++; $display("FAIL first_scan_tdo_en: got %0d cycles expected 8", en_cnt); end
`endif
  endtask

  task automatic test_ir_capture();
    logic [IR_WIDTH-1:0] dout, exp;
    clear_obs();
    exp_q.push_back(1'b1);
    for (int i = 1; i < IR_WIDTH; i++) exp_q.push_back(1'b0);
    ir_scan(5'h10, dout);
    for (int i = 0; i < IR_WIDTH; i++) exp[i] = exp_q.pop_front();
    checks++; if (dout !== exp) begin errors++; $display("FAIL ir_capture: got %b expected %b", dout, exp); end
    checks++; if (io_ir !== 5'h10) begin errors++; $display("FAIL ir_update: got %h expected 10", io_ir); end
    checks++; if (en_cnt != IR_WIDTH) begin errors++; $display("FAIL ir_tdo_en: got %0d expected %0d", en_cnt, IR_WIDTH); end
  endtask

  task automatic test_chain_rw(input int k, input logic [31:0] cap0, input logic [31:0] cap1,
                               input logic [31:0] wr);
    logic [IR_WIDTH-1:0] irout;
    logic [63:0] dout, exp;
    logic [31:0] capk;
    logic [NUM_CHAINS+CHAIN_WIDTH-1:0] e, o;
    ir_scan(IR_WIDTH'(5'h10 + k), irout);
    io_chain_capture_data = {cap1, cap0};
    capk = (k == 0) ? cap0 : cap1;
    clear_obs();
    for (int i = 0; i < 32; i++) exp_q.push_back(capk[i]);
    upd_exp_q.push_back({NUM_CHAINS'(1 << k), wr});
    dr_scan(32, {32'h0, wr}, dout);
    exp = '0;
    for (int i = 0; i < 32; i++) exp[i] = exp_q.pop_front();
    checks++; if (dout !== exp) begin errors++; $display("FAIL chain%0d_tdo: got %h expected %h", k, dout, exp); end
    checks++; if (cap_cnt != 1 || cap_mask !== NUM_CHAINS'(1 << k)) begin errors++; $display("FAIL chain%0d_capture: got %0d cycles mask %b expected 1 cycle mask %b", k, cap_cnt, cap_mask, NUM_CHAINS'(1 << k)); end
    checks++; if (io_chain_update_valid !== NUM_CHAINS'(1 << k) || io_chain_update_data !== wr) begin errors++; $display("FAIL chain%0d_update: got %b/%h expected %b/%h", k, io_chain_update_valid, io_chain_update_data, NUM_CHAINS'(1 << k), wr); end
    clk(1'b0, 1'b0);
    checks++; if (io_chain_update_valid !== '0) begin errors++; $display("FAIL chain%0d_pulse_width: got %b expected 00", k, io_chain_update_valid); end
    e = upd_exp_q.pop_front();
    o = (upd_obs_q.size() > 0) ? upd_obs_q.pop_front() : '0;
    checks++; if (o !== e || upd_cnt != 1) begin errors++; $display("FAIL chain%0d_scoreboard: got %h (%0d pulses) expected %h (1 pulse)", k, o, upd_cnt, e); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] dout;
    logic [NUM_CHAINS+CHAIN_WIDTH-1:0] e, o;
    logic [31:0] vals [3] = '{32'hA5A5_0F0F, 32'h0000_0001, 32'h8000_0000};
    clear_obs();
    foreach (vals[i]) begin
      upd_exp_q.push_back({2'b10, vals[i]});
      dr_scan(32, {32'h0, vals[i]}, dout);
    end
    clk(1'b0, 1'b0);
    checks++; if (upd_cnt != 3) begin errors++; $display("FAIL b2b_count: got %0d pulses expected 3", upd_cnt); end
    while (upd_exp_q.size() > 0) begin
      e = upd_exp_q.pop_front();
      o = (upd_obs_q.size() > 0) ? upd_obs_q.pop_front() : '0;
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_update: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_bypass();
    logic [IR_WIDTH-1:0] irout;
    logic [IR_WIDTH-1:0] instrs [3] = '{5'h03, 5'h1F, 5'h12};
    logic [63:0] din, dout, exp;
    foreach (instrs[j]) begin
      ir_scan(instrs[j], irout);
      clear_obs();
      din = 64'($urandom_range(0, 1023));
      exp_q.push_back(1'b0);
      for (int i = 0; i < 9; i++) exp_q.push_back(din[i]);
      dr_scan(10, din, dout);
      exp = '0;
      for (int i = 0; i < 10; i++) exp[i] = exp_q.pop_front();
      checks++; if (dout !== exp) begin errors++; $display("FAIL bypass_ir%h: got %h expected %h", instrs[j], dout, exp); end
      checks++; if (cap_cnt != 0 || upd_cnt != 0) begin errors++; $display("FAIL bypass_ir%h_side: got cap=%0d upd=%0d expected 0/0", instrs[j], cap_cnt, upd_cnt); end
    end
  endtask

  task automatic test_tlr_return();
    logic [IR_WIDTH-1:0] irout;
    ir_scan(5'h03, irout);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    checks++; if (io_state !== 4'h2) begin errors++; $display("FAIL tlr_in_shift: got %h expected 2", io_state); end
    repeat (5) clk(1'b1, 1'b0);
    checks++; if (io_state !== 4'hF) begin errors++; $display("FAIL tlr_state: got %h expected f", io_state); end
    checks++; if (io_ir !== RESET_IR) begin errors++; $display("FAIL tlr_ir: got %h expected %h", io_ir, RESET_IR); end
    clk(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    logic [IR_WIDTH-1:0] irout;
    ir_scan(5'h10, irout);
    clear_obs();
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    repeat (9) clk(1'b0, 1'b1);
    checks++; if (io_state !== 4'h2) begin errors++; $display("FAIL mid_in_shift: got %h expected 2", io_state); end
    #2 reset = 1'b1;
    #1;
    checks++; if (io_state !== 4'hF || io_tdo_en !== 1'b0) begin errors++; $display("FAIL mid_async_reset: got state %h en %b expected f/0", io_state, io_tdo_en); end
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (8) clk(1'b0, 1'b0);
    checks++; if (upd_cnt != 0 || io_chain_update_data !== '0) begin errors++; $display("FAIL mid_no_update: got %0d pulses data %h expected 0/0", upd_cnt, io_chain_update_data); end
    checks++; if (io_ir !== RESET_IR) begin errors++; $display("FAIL mid_ir: got %h expected %h", io_ir, RESET_IR); end
  endtask

  initial begin
    test_reset();
    test_first_dr_scan();
    test_ir_capture();
    test_chain_rw(0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678);
    test_chain_rw(1, 32'h1357_9BDF, 32'h0F1E_2D3C, 32'h0BAD_F00D);
    test_back_to_back();
    test_bypass();
    test_tlr_return();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
